// File: rtl/vga_scanout_if.sv
// Framebuffer-in / VGA-out bundle for vga_scanout.
// master: the scanout engine; slave: the framebuffer producer / display monitor.
interface vga_scanout_if;
  logic [1199:0] framebuffer;
  logic [3:0]    red_out;
  logic [3:0]    green_out;
  logic [3:0]    blue_out;
  logic          h_sync_out;
  logic          v_sync_out;
  logic          frame_start;

  modport master (
    input  framebuffer,
    output red_out, green_out, blue_out, h_sync_out, v_sync_out, frame_start
  );

  modport slave (
    output framebuffer,
    input  red_out, green_out, blue_out, h_sync_out, v_sync_out, frame_start
  );
endinterface

// File: rtl/vga_scanout.sv
// 640x480@60 VGA scanout of a 40x30 cell framebuffer (16x16-pixel cells), snapshotted per frame.
// Optional macro CELL_GRID_EN draws a 12'h444 line on every cell boundary.
module vga_scanout #(
  parameter logic [11:0] FG_COLOR  = 12'hFFF,
  parameter logic [11:0] BG_COLOR  = 12'h000,
  parameter int unsigned H_VISIBLE = 640,
  parameter int unsigned H_FRONT   = 16,
  parameter int unsigned H_SYNC    = 96,
  parameter int unsigned H_BACK    = 48,
  parameter int unsigned V_VISIBLE = 480,
  parameter int unsigned V_FRONT   = 10,
  parameter int unsigned V_SYNC    = 2,
  parameter int unsigned V_BACK    = 33
) (
  input  logic          clock,
  input  logic          reset_button,
  vga_scanout_if.master vga
);

  localparam int unsigned H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
  localparam int unsigned V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

  localparam logic [9:0] H_LAST       = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_LAST       = 10'(V_TOTAL - 1);
  localparam logic [9:0] H_VIS_END    = 10'(H_VISIBLE);
  localparam logic [9:0] V_VIS_END    = 10'(V_VISIBLE);
  localparam logic [9:0] H_SYNC_FIRST = 10'(H_VISIBLE + H_FRONT);
  localparam logic [9:0] H_SYNC_LAST  = 10'(H_VISIBLE + H_FRONT + H_SYNC - 1);
  localparam logic [9:0] V_SYNC_FIRST = 10'(V_VISIBLE + V_FRONT);
  localparam logic [9:0] V_SYNC_LAST  = 10'(V_VISIBLE + V_FRONT + V_SYNC - 1);

  logic          pix_en_q;
  logic [9:0]    h_count_q, h_count_d;
  logic [9:0]    v_count_q, v_count_d;
  logic [1199:0] snapshot_q, snapshot_d;
  logic [11:0]   rgb_q, rgb_d;
  logic          h_sync_q, h_sync_d;
  logic          v_sync_q, v_sync_d;
  logic          frame_start_q, frame_start_d;

  logic          visible;
  logic          snap_now;
  logic [4:0]    row;
  logic [5:0]    col;
  logic [10:0]   cell_idx;
  logic          cell_lit;
  logic [11:0]   pixel_color;

  assign visible  = (h_count_q < H_VIS_END) && (v_count_q < V_VIS_END);
  assign row      = v_count_q[8:4];
  assign col      = h_count_q[9:4];
  assign cell_idx = 11'(row) * 11'd40 + 11'(col);
  assign cell_lit = snapshot_q[cell_idx];
  // Snapshot at the first pixel of vertical blanking so a frame never tears.
  assign snap_now = pix_en_q && (h_count_q == 10'd0) && (v_count_q == V_VIS_END);

`ifdef CELL_GRID_EN
  assign pixel_color = ((h_count_q[3:0] == 4'd0) || (v_count_q[3:0] == 4'd0)) ? 12'h444 :
                       (cell_lit ? FG_COLOR : BG_COLOR);
`else
  assign pixel_color = cell_lit ? FG_COLOR : BG_COLOR;
`endif

  always_comb begin
    h_count_d     = h_count_q;
    v_count_d     = v_count_q;
    snapshot_d    = snapshot_q;
    rgb_d         = rgb_q;
    h_sync_d      = h_sync_q;
    v_sync_d      = v_sync_q;
    frame_start_d = snap_now;
    if (pix_en_q) begin
      if (h_count_q == H_LAST) begin
        h_count_d = 10'd0;
        v_count_d = (v_count_q == V_LAST) ? 10'd0 : v_count_q + 10'd1;
      end else begin
        h_count_d = h_count_q + 10'd1;
      end
      // Colour and syncs come from the same counts, so they stay aligned one pixel later.
      h_sync_d = !((h_count_q >= H_SYNC_FIRST) && (h_count_q <= H_SYNC_LAST));
      v_sync_d = !((v_count_q >= V_SYNC_FIRST) && (v_count_q <= V_SYNC_LAST));
      rgb_d    = visible ? pixel_color : 12'h000;
      if (snap_now) begin
        snapshot_d = vga.framebuffer;
      end
    end
  end

  always_ff @(posedge clock or negedge reset_button) begin
    if (!reset_button) begin
      pix_en_q      <= 1'b0;
      h_count_q     <= 10'd0;
      v_count_q     <= 10'd0;
      snapshot_q    <= '0;
      rgb_q         <= 12'h000;
      h_sync_q      <= 1'b1;
      v_sync_q      <= 1'b1;
      frame_start_q <= 1'b0;
    end else begin
      pix_en_q      <= ~pix_en_q;
      h_count_q     <= h_count_d;
      v_count_q     <= v_count_d;
      snapshot_q    <= snapshot_d;
      rgb_q         <= rgb_d;
      h_sync_q      <= h_sync_d;
      v_sync_q      <= v_sync_d;
      frame_start_q <= frame_start_d;
    end
  end

  assign vga.red_out     = rgb_q[11:8];
  assign vga.green_out   = rgb_q[7:4];
  assign vga.blue_out    = rgb_q[3:0];
  assign vga.h_sync_out  = h_sync_q;
  assign vga.v_sync_out  = v_sync_q;
  assign vga.frame_start = frame_start_q;

endmodule

// File: tb/tb_vga_scanout.sv
// Self-checking bench for vga_scanout, using a shrunken raster (96x38) so several frames fit in a short run.
// Expected outputs come from an edge-count model: raster position = edges/2 - 1.
module tb_vga_scanout;

  localparam int unsigned HV = 64, HF = 8, HS = 16, HB = 8;
  localparam int unsigned VV = 32, VF = 2, VS = 2, VB = 2;
  localparam int unsigned HT = HV + HF + HS + HB;
  localparam int unsigned VT = VV + VF + VS + VB;

`ifdef CELL_GRID_EN
  localparam logic [11:0] PIN_X0Y0 = 12'h444, PIN_X16Y0 = 12'h444;
  localparam logic [11:0] PIN_X15Y15 = 12'hFFF, PIN_X0Y16 = 12'h444;
`else
  localparam logic [11:0] PIN_X0Y0 = 12'hFFF, PIN_X16Y0 = 12'h000;
  localparam logic [11:0] PIN_X15Y15 = 12'hFFF, PIN_X0Y16 = 12'h000;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  always #10 clk = ~clk;

  vga_scanout_if bus ();

  vga_scanout #(
    .FG_COLOR(12'hFFF), .BG_COLOR(12'h000),
    .H_VISIBLE(HV), .H_FRONT(HF), .H_SYNC(HS), .H_BACK(HB),
    .V_VISIBLE(VV), .V_FRONT(VF), .V_SYNC(VS), .V_BACK(VB)
  ) dut (
    .clock(clk),
    .reset_button(rst_n),
    .vga(bus)
  );

  int n_checks = 0;
  int n_fail = 0;
  bit cmp_en = 1'b0;

  // ---------------- reference model ----------------
  int unsigned   edge_cnt;
  logic [1199:0] m_snap;
  logic [11:0]   m_rgb;
  logic          m_hs, m_vs, m_fs;

  function automatic int unsigned hx(input int unsigned p); return p % HT; endfunction
  function automatic int unsigned vy(input int unsigned p); return (p / HT) % VT; endfunction

  function automatic logic [11:0] exp_rgb(input int unsigned p, input logic [1199:0] snap);
    int unsigned x, y;
    x = hx(p);
    y = vy(p);
    if (x >= HV || y >= VV) return 12'h000;
`ifdef CELL_GRID_EN
    if (x % 16 == 0 || y % 16 == 0) return 12'h444;
`endif
    return snap[(y / 16) * 40 + x / 16] ? 12'hFFF : 12'h000;
  endfunction

  function automatic logic exp_hs(input int unsigned p);
    return !(hx(p) >= HV + HF && hx(p) < HV + HF + HS);
  endfunction

  function automatic logic exp_vs(input int unsigned p);
    return !(vy(p) >= VV + VF && vy(p) < VV + VF + VS);
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      edge_cnt <= 0;
      m_snap   <= '0;
      m_rgb    <= 12'h000;
      m_hs     <= 1'b1;
      m_vs     <= 1'b1;
      m_fs     <= 1'b0;
    end else begin
      edge_cnt <= edge_cnt + 1;
      m_fs     <= 1'b0;
      if ((edge_cnt + 1) % 2 == 0) begin
        m_rgb <= exp_rgb((edge_cnt + 1) / 2 - 1, m_snap);
        m_hs  <= exp_hs((edge_cnt + 1) / 2 - 1);
        m_vs  <= exp_vs((edge_cnt + 1) / 2 - 1);
        if (hx((edge_cnt + 1) / 2 - 1) == 0 && vy((edge_cnt + 1) / 2 - 1) == VV) begin
          m_snap <= bus.framebuffer;
          m_fs   <= 1'b1;
        end
      end
    end
  end

  // ---------------- checking ----------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t edge=%0d)", name, act, exp, $time, edge_cnt);
    end
  endtask

  function automatic logic [11:0] dut_rgb();
    return {bus.red_out, bus.green_out, bus.blue_out};
  endfunction

  always @(negedge clk) begin
    if (cmp_en) begin
      check("rgb", 32'(dut_rgb()), 32'(m_rgb));
      check("h_sync", 32'(bus.h_sync_out), 32'(m_hs));
      check("v_sync", 32'(bus.v_sync_out), 32'(m_vs));
      check("frame_start", 32'(bus.frame_start), 32'(m_fs));
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic rand_fb();
    logic [1199:0] v;
    for (int i = 0; i < 37; i++) v[i*32 +: 32] = $urandom;
    v[1199:1184] = 16'($urandom);
    bus.framebuffer = v;
  endtask

  task automatic at_edge(input int unsigned target);
    int n = 0;
    while (edge_cnt < target && n < 50000) begin
      @(negedge clk);
      n++;
    end
    check("at_edge_reached", edge_cnt, target);
  endtask

  task automatic wait_fs(output bit found);
    int n = 0;
    found = 1'b0;
    while (n < 20000) begin
      @(negedge clk);
      n++;
      if (bus.frame_start === 1'b1) begin
        found = 1'b1;
        break;
      end
    end
    if (!found) check("frame_start_timeout", 32'd0, 32'd1);
  endtask

  function automatic logic sync_sig(input bit use_v);
    return use_v ? bus.v_sync_out : bus.h_sync_out;
  endfunction

  task automatic measure_low(input bit use_v, output int low_len, output int period);
    int n = 0;
    low_len = 0;
    period  = 0;
    while (sync_sig(use_v) !== 1'b1 && n < 20000) begin @(negedge clk); n++; end
    while (sync_sig(use_v) !== 1'b0 && n < 20000) begin @(negedge clk); n++; end
    while (sync_sig(use_v) === 1'b0 && n < 20000) begin low_len++; @(negedge clk); n++; end
    period = low_len;
    while (sync_sig(use_v) === 1'b1 && n < 20000) begin period++; @(negedge clk); n++; end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_rgb"}, 32'(dut_rgb()), 32'h0);
    check({tag, "_hsync"}, 32'(bus.h_sync_out), 32'd1);
    check({tag, "_vsync"}, 32'(bus.v_sync_out), 32'd1);
    check({tag, "_frame_start"}, 32'(bus.frame_start), 32'd0);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int unsigned fs_e;
    int lo, per, cnt;
    bit found;
    logic [1199:0] v;

    bus.framebuffer = '0;
    bus.framebuffer[0] = 1'b1;
    #1 rst_n = 1'b0;
    cmp_en = 1'b1;
    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    rst_n = 1'b1;

    // First snapshot lands on update 32*96+1, i.e. rising edge 6146 after release.
    wait_fs(found);
    check("first_snapshot_edge", edge_cnt, 32'd6146);
    fs_e = edge_cnt;

    // New data after the snapshot must stay invisible until the next one.
    rand_fb();
    v = bus.framebuffer;
    v[0] = 1'b0; v[1] = 1'b1; v[40] = 1'b1;
    bus.framebuffer = v;

    at_edge(fs_e + 1152);  check("pin_x0_y0", 32'(dut_rgb()), 32'(PIN_X0Y0));
    at_edge(fs_e + 1184);  check("pin_x16_y0", 32'(dut_rgb()), 32'(PIN_X16Y0));
    at_edge(fs_e + 4062);  check("pin_x15_y15", 32'(dut_rgb()), 32'(PIN_X15Y15));
    at_edge(fs_e + 4224);  check("pin_x0_y16", 32'(dut_rgb()), 32'(PIN_X0Y16));

    measure_low(1'b0, lo, per);
    check("hsync_low_clocks", 32'(lo), 32'd32);
    check("line_period_clocks", 32'(per), 32'd192);
    measure_low(1'b1, lo, per);
    check("vsync_low_clocks", 32'(lo), 32'd384);
    check("frame_period_vsync", 32'(per), 32'd7296);

    wait_fs(found);
    cnt = 0;
    do begin @(negedge clk); cnt++; end while (bus.frame_start !== 1'b1 && cnt < 20000);
    check("frame_period_fs", 32'(cnt), 32'd7296);

    // Random framebuffer churn at arbitrary points in the raster.
    for (int t = 0; t < 12; t++) begin
      repeat ($urandom_range(200, 1400)) @(negedge clk);
      rand_fb();
    end

    // Asynchronous reset between clock edges.
    #3 rst_n = 1'b0;
    #1 check_reset_outputs("async_reset");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // Reset again at h=40, v=20 of the fresh raster.
    at_edge(2 * (20 * HT + 40) + 2);
    #3 rst_n = 1'b0;
    #1 check_reset_outputs("midframe_reset");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    rand_fb();

    // Snapshot is cleared: a visible pixel (x5,y5) stays black before the first frame_start.
    at_edge(2 * (5 * HT + 5) + 2);
    check("black_before_snapshot", 32'(dut_rgb()), 32'h0);
    wait_fs(found);
    check("restart_snapshot_edge", edge_cnt, 32'd6146);
    repeat (3000) @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/vga_scanout.md
Name: vga_scanout

Overview:
- Downstream consumer of the Display stage's 1200-bit `framebuffer`: a 40x30 grid of cells, each 16x16 pixels.
- Generates 640x480@60 Hz VGA timing from the 50 MHz board clock and drives 4-bit-per-channel RGB plus active-low syncs to the DE0 VGA DAC.
- Snapshots the framebuffer once per frame, at the start of vertical blanking, so a frame never tears.

Parameters:
- FG_COLOR, 12'hFFF, {R,G,B} nibbles for a lit cell.
- BG_COLOR, 12'h000, {R,G,B} nibbles for an unlit cell inside the visible area.
- H_VISIBLE, 640 / H_FRONT, 16 / H_SYNC, 96 / H_BACK, 48: horizontal timing in pixels; total 800.
- V_VISIBLE, 480 / V_FRONT, 10 / V_SYNC, 2 / V_BACK, 33: vertical timing in lines; total 525.

Ports:
- clock  input  1  50 MHz system clock (CLOCK_50 at top level)
- reset_button  input  1  asynchronous, active-low reset
- framebuffer  input  1200  cell bits; bit index = row*40 + col (row 0..29, col 0..39); 1 = lit
- red_out  output  4  red channel
- green_out  output  4  green channel
- blue_out  output  4  blue channel
- h_sync_out  output  1  horizontal sync, active-low
- v_sync_out  output  1  vertical sync, active-low
- frame_start  output  1  one-clock pulse when the snapshot is taken

Behaviour:
- Reset (reset_button = 0, asynchronous):
  - pix_en = 0, h_count = 0, v_count = 0, snapshot = 0.
  - RGB outputs = 0, h_sync_out = 1, v_sync_out = 1, frame_start = 0.
- Pixel enable:
  - pix_en toggles every clock, so the 25 MHz pixel rate is 1 of 2 clocks.
  - All counters and outputs update only on clocks where pix_en = 1, except frame_start (see below).
  - After reset release, the first update occurs on the 2nd rising edge.
- Counters:
  - h_count counts 0..799 and wraps to 0.
  - v_count increments when h_count wraps; counts 0..524 and wraps to 0.
- Sync windows, from the current counts, registered:
  - h_sync_out = 0 for h_count in [656, 751].
  - v_sync_out = 0 for v_count in [490, 491].
- Visible area is h_count < 640 and v_count < 480.
  - col = h_count[9:4], row = v_count[8:4].
  - Pixel = FG_COLOR if snapshot[row*40+col] = 1, else BG_COLOR.
  - Outside the visible area, RGB = 0.
  - Index computation is fully within range in the visible area; no index ≥ 1200 is ever read.
- Latency and alignment:
  - RGB and both syncs are registered in the same stage.
  - The counter state at update N appears on the outputs at update N+1 (one pixel), so colour and syncs stay mutually aligned.
- Snapshot:
  - Taken on the pix_en clock where h_count = 0 and v_count = 480: snapshot <= framebuffer.
  - frame_start is high for exactly that one clock.
  - framebuffer changes at any other time have no effect until the next snapshot.
- Simultaneous events: the h wrap and v wrap on the same update take v_count from 524 to 0; no extra line is added.
- Reset mid-frame:
  - All outputs return to their reset values immediately.
  - After release, the counters restart from 0,0 and the screen stays black until the first snapshot (v_count = 480).
- Framebuffer bits are treated as quasi-static; no synchroniser is required, since the source is in the same clock domain.

Optional Feature:
- Macro: CELL_GRID_EN.
- Defined: in the visible area, a pixel with h_count[3:0] = 0 or v_count[3:0] = 0 outputs 12'h444 instead of the cell colour, i.e. a 1-pixel grid line on every cell boundary.
  - The grid overrides FG_COLOR and BG_COLOR.
  - Blanking still outputs 0.
- Undefined: no grid logic; cell colour only.

Test Plan:
- Reset, then free-run: h_sync_out low for 96 pixel times (192 clocks) per line; line period 1600 clocks; v_sync_out low for exactly 2 lines; frame period 840000 clocks.
- framebuffer = 0 except bit 0: after frame_start, output is FG_COLOR (12'hFFF) for pixels x 0..15, y 0..15 and BG_COLOR elsewhere visible; RGB = 0 during blanking.
- framebuffer bit 1199 only: FG_COLOR only at x 624..639, y 464..479 (row 29, col 39).
- Change framebuffer mid-frame (v_count = 200): output is unchanged for the rest of that frame; the new data appears only after the next frame_start pulse at v_count = 480.
- Assert reset_button at h_count = 300, v_count = 100: outputs go to RGB 0 and syncs 1 asynchronously; after release, h_count and v_count resume from 0.
- With CELL_GRID_EN defined and framebuffer all ones: pixels at x = 0, 16, 32… and y = 0, 16… output 12'h444; all other visible pixels output 12'hFFF.
